// File: rtl/div3_pkg.sv
// rtl/div3_pkg.sv - shared types, widths and reference model for the serial divide-by-3 unit
//
// Purpose : FSM state encoding, remainder width and a behavioural reference
//           function returning quotient and remainder of value / 3.
// Ports   : none (package).
package div3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div3_state_t;

   localparam int REM_W = 2;

   typedef struct packed {
      logic [63:0]      quotient;
      logic [REM_W-1:0] remainder;
   } div3_result_t;

   function automatic div3_result_t div3_model(input logic [63:0] value);
      div3_result_t res;
      res.quotient  = value / 64'd3;
      res.remainder = REM_W'(value % 64'd3);
      return res;
   endfunction

endpackage

// File: rtl/div3_step.sv
// rtl/div3_step.sv - one MSB-first long-division step by 3
//
// Purpose : combinational remainder-machine step, t = 2*r + b.
// Ports   : r      - current remainder (0..2)
//           b      - next dividend bit
//           r_next - remainder after this bit
//           q_bit  - quotient bit produced by this step
module div3_step
   import div3_pkg::*;
(
   input  logic [REM_W-1:0] r,
   input  logic             b,
   output logic [REM_W-1:0] r_next,
   output logic             q_bit
);

   logic [2:0] t;

   always_comb begin
      // 2*r + b is just the remainder with the new bit appended.
      t      = {r, b};
      q_bit  = (t >= 3'd3);
      r_next = q_bit ? REM_W'(t - 3'd3) : t[REM_W-1:0];
   end

endmodule

// File: rtl/div3_serial.sv
// rtl/div3_serial.sv - sequential divide-by-3, one dividend bit per clock
//
// Purpose : accepts an operand over in_valid/in_ready, performs MSB-first long
//           division by 3 in DATA_W cycles, presents quotient/remainder and a
//           divisibility flag over out_valid/out_ready.
// Ports   : clk, rst_n (async, active low)
//           in_valid, in_ready, in_data[DATA_W-1:0]   - operand handshake
//           out_valid, out_ready                      - result handshake
//           quotient[DATA_W-1:0], remainder[1:0], divisible - registered result
module div3_serial
   import div3_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] quotient,
   output logic [REM_W-1:0]  remainder,
   output logic              divisible
);

   localparam int CNT_W = $clog2(DATA_W);

   div3_state_t       state_q;
   div3_state_t       state_d;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] quot_q;
   logic [REM_W-1:0]  rem_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_ready_q;
   logic              in_ready_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic [DATA_W-1:0] quotient_q;
   logic [REM_W-1:0]  remainder_q;
   logic              divisible_q;

   logic [REM_W-1:0]  r_next;
   logic              q_bit;
   logic [DATA_W-1:0] quot_shifted;
   logic              accept;
   logic              last_bit;

   div3_step u_step (
      .r      (rem_q),
      .b      (shift_q[DATA_W-1]),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   assign accept       = (state_q == IDLE) && in_valid && in_ready_q;
   assign last_bit     = (cnt_q == '0);
   assign quot_shifted = {quot_q[DATA_W-2:0], q_bit};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept)                   state_d = RUN;
         RUN:  if (last_bit)                 state_d = DONE;
         DONE: if (out_valid_q && out_ready) state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // Handshake outputs are registered, so they are derived from the state
   // being entered rather than the current one.
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Datapath: shift register, running quotient, remainder and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         shift_q <= in_data;
         quot_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= CNT_W'(DATA_W - 1);
      end else if (state_q == RUN) begin
         shift_q <= {shift_q[DATA_W-2:0], 1'b0};
         quot_q  <= quot_shifted;
         rem_q   <= r_next;
         cnt_q   <= cnt_q - 1'b1;
      end
   end

   // Result registers load once, on the final bit, so they stay put through
   // DONE and after the output handshake until the next result is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient_q  <= '0;
         remainder_q <= '0;
         divisible_q <= 1'b0;
      end else if ((state_q == RUN) && last_bit) begin
         quotient_q  <= quot_shifted;
         remainder_q <= r_next;
         divisible_q <= (r_next == '0);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign divisible = divisible_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert (rem_q != 2'd3);
      end
   end
`endif

endmodule

// File: tb/tb_div3_serial.sv
// tb/tb_div3_serial.sv - self-checking bench for div3_serial at DATA_W=8 and DATA_W=5
module tb_div3_serial;
   import div3_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       in_valid8, in_ready8, out_valid8, out_ready8, divisible8;
   logic [7:0] in_data8, quotient8;
   logic [1:0] remainder8;

   logic       in_valid5, in_ready5, out_valid5, out_ready5, divisible5;
   logic [4:0] in_data5, quotient5;
   logic [1:0] remainder5;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   div3_serial #(.DATA_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .quotient(quotient8), .remainder(remainder8), .divisible(divisible8)
   );

   div3_serial #(.DATA_W(5)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
      .out_valid(out_valid5), .out_ready(out_ready5),
      .quotient(quotient5), .remainder(remainder5), .divisible(divisible5)
   );

   typedef struct {
      logic [7:0] d;
      logic [7:0] q;
      logic [1:0] r;
      logic       dv;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Divisibility by 3 from bit weights (2^i mod 3 alternates 1,2).
   function automatic logic chk3(input logic [63:0] v, input int w);
      int s = 0;
      for (int i = 0; i < w; i++) begin
         if (v[i]) s += (i % 2 == 0) ? 1 : 2;
      end
      return (s % 3) == 0;
   endfunction

   // Returns at the negedge following the accept edge.
   task automatic accept8(input logic [7:0] d, input logic keep_valid);
      int n = 0;
      @(negedge clk);
      in_valid8 = 1'b1;
      in_data8  = d;
      while (!in_ready8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept8_ready", 64'(in_ready8), 64'd1);
      @(negedge clk);
      if (!keep_valid) in_valid8 = 1'b0;
   endtask

   task automatic wait_out8(output int lat);
      lat = 0;
      while (!out_valid8 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic accept5(input logic [4:0] d);
      int n = 0;
      @(negedge clk);
      in_valid5 = 1'b1;
      in_data5  = d;
      while (!in_ready5 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept5_ready", 64'(in_ready5), 64'd1);
      @(negedge clk);
      in_valid5 = 1'b0;
   endtask

   task automatic wait_out5(output int lat);
      lat = 0;
      while (!out_valid5 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      div3_result_t m;

      vecs[0] = '{d: 8'd0,   q: 8'd0,  r: 2'd0, dv: 1'b1};
      vecs[1] = '{d: 8'd255, q: 8'd85, r: 2'd0, dv: 1'b1};
      vecs[2] = '{d: 8'd200, q: 8'd66, r: 2'd2, dv: 1'b0};
      vecs[3] = '{d: 8'd7,   q: 8'd2,  r: 2'd1, dv: 1'b0};

      rst_n = 1'b0;
      in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
      in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready",  64'(in_ready8),   64'd0);
      check("rst_out_valid", 64'(out_valid8),  64'd0);
      check("rst_quotient",  64'(quotient8),   64'd0);
      check("rst_remainder", 64'(remainder8),  64'd0);
      check("rst_divisible", 64'(divisible8),  64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready8", 64'(in_ready8), 64'd1);
      check("post_rst_in_ready5", 64'(in_ready5), 64'd1);

      // Known operands with out_ready held high
      for (int i = 0; i < 4; i++) begin
         accept8(vecs[i].d, 1'b0);
         wait_out8(lat);
         check("vec_latency",   64'(lat),        64'd8);
         check("vec_quotient",  64'(quotient8),  64'(vecs[i].q));
         check("vec_remainder", 64'(remainder8), 64'(vecs[i].r));
         check("vec_divisible", 64'(divisible8), 64'(vecs[i].dv));
         @(negedge clk);
         check("vec_out_valid_drop", 64'(out_valid8), 64'd0);
         check("vec_in_ready_back",  64'(in_ready8),  64'd1);
      end

      // Backpressure: 100 -> 33/1/0, stalled five cycles with stray in_valid
      out_ready8 = 1'b0;
      accept8(8'd100, 1'b0);
      wait_out8(lat);
      check("bp_latency", 64'(lat), 64'd8);
      for (int i = 0; i < 5; i++) begin
         check("bp_quotient",  64'(quotient8),  64'd33);
         check("bp_remainder", 64'(remainder8), 64'd1);
         check("bp_divisible", 64'(divisible8), 64'd0);
         check("bp_in_ready",  64'(in_ready8),  64'd0);
         check("bp_out_valid", 64'(out_valid8), 64'd1);
         in_valid8 = (i % 2 == 0);
         in_data8  = 8'd50;
         @(negedge clk);
      end
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      @(negedge clk);
      check("bp_out_valid_drop", 64'(out_valid8), 64'd0);
      check("bp_in_ready_back",  64'(in_ready8),  64'd1);
      check("bp_quotient_hold",  64'(quotient8),  64'd33);

      // Back-to-back: 9 then 10 with in_valid held high
      accept8(8'd9, 1'b1);
      in_data8 = 8'd10;
      wait_out8(lat);
      check("b2b_latency0",   64'(lat),        64'd8);
      check("b2b_quotient0",  64'(quotient8),  64'd3);
      check("b2b_remainder0", 64'(remainder8), 64'd0);
      check("b2b_divisible0", 64'(divisible8), 64'd1);
      @(negedge clk);
      check("b2b_ready_after_hs", 64'(in_ready8), 64'd1);
      @(negedge clk);
      check("b2b_second_accept",  64'(in_ready8), 64'd0);
      in_valid8 = 1'b0;
      wait_out8(lat);
      check("b2b_latency1",   64'(lat),        64'd8);
      check("b2b_quotient1",  64'(quotient8),  64'd3);
      check("b2b_remainder1", 64'(remainder8), 64'd1);
      check("b2b_divisible1", 64'(divisible8), 64'd0);
      @(negedge clk);

      // Reset four cycles into computing 150
      accept8(8'd150, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid8), 64'd0);
      check("midrst_in_ready",  64'(in_ready8),  64'd0);
      check("midrst_quotient",  64'(quotient8),  64'd0);
      check("midrst_remainder", 64'(remainder8), 64'd0);
      check("midrst_divisible", 64'(divisible8), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("midrst_no_out_valid", 64'(out_valid8), 64'd0);
      end
      check("midrst_in_ready_back", 64'(in_ready8), 64'd1);
      accept8(8'd150, 1'b0);
      wait_out8(lat);
      check("fresh_latency",   64'(lat),        64'd8);
      check("fresh_quotient",  64'(quotient8),  64'd50);
      check("fresh_remainder", 64'(remainder8), 64'd0);
      check("fresh_divisible", 64'(divisible8), 64'd1);
      @(negedge clk);

      // Exhaustive sweep at DATA_W=5
      for (int v = 0; v < 32; v++) begin
         m = div3_model(64'(v));
         accept5(5'(v));
         wait_out5(lat);
         check("w5_latency",   64'(lat),        64'd5);
         check("w5_quotient",  64'(quotient5),  m.quotient);
         check("w5_remainder", 64'(remainder5), 64'(m.remainder));
         check("w5_divisible", 64'(divisible5), 64'(chk3(64'(v), 5)));
         @(negedge clk);
      end
      check("w5_q31", 64'(quotient5),  64'd10);
      check("w5_r31", 64'(remainder5), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div3_serial.md
# div3_serial

Sequential divide-by-3 unit. It accepts a DATA_W-bit unsigned operand over a valid/ready handshake and performs MSB-first long division through a 3-state remainder machine, one bit per clock. It returns the quotient, the remainder and a divisibility flag over a second valid/ready handshake. It is the producing counterpart to the combinational divisibility-by-3 checker: it generates the full quotient/remainder, and its `divisible` output must agree with the checker for every operand.

## Interface

**Parameters**
- `DATA_W`, default 8: operand and quotient width. Legal range is 2 to 64.

**Ports**
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operand valid.
- `in_ready`, out, 1: block can accept an operand.
- `in_data`, in, DATA_W: unsigned dividend.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `quotient`, out, DATA_W: `in_data / 3`.
- `remainder`, out, 2: `in_data % 3`, in the range 0..2.
- `divisible`, out, 1: 1 when `remainder == 0`.

## Operation

**States:** IDLE, RUN, DONE.

**IDLE**
- `in_ready = 1`.
- On `in_valid && in_ready`:
  - latch `in_data` into the shift register;
  - clear the remainder register to 0;
  - load the bit counter with DATA_W−1;
  - go to RUN.

**RUN**
- `in_ready = 0`. Each cycle, consume shift-register bit b (MSB first):
  - `t = 2*r + b`, with t in 0..5;
  - `q_bit = (t >= 3)`;
  - `r_next = q_bit ? t-3 : t`;
  - shift `q_bit` into the quotient LSB.
- When the counter reaches 0 and that last bit is processed, go to DONE. Otherwise decrement the counter.

**DONE**
- `out_valid = 1`. `quotient`, `remainder` and `divisible` are held stable until `out_valid && out_ready`. On that handshake, go to IDLE.

**Arithmetic and width rules**
- The remainder register is 2 bits wide and never holds 3. Reaching 3 is an assertion failure.
- The counter width is `$clog2(DATA_W)`.

**Output values**
- All outputs are registered.
- Reset values:
  - `in_ready = 0` while `rst_n` is low, and 1 in the first cycle after reset is released;
  - `out_valid = 0`;
  - `quotient = 0`;
  - `remainder = 0`;
  - `divisible = 0`.
- After an output handshake, the result outputs keep their last value and `out_valid` drops.

**Boundary conditions**
- **`in_valid` outside IDLE:** ignored, with no effect on the computation in progress.
- **`out_ready` high before DONE:** no effect.
- **Input and output handshakes in the same cycle:** cannot occur, because `in_ready` is 0 in DONE. A new operand is accepted in the cycle after the output handshake at the earliest.
- **Reset asserted in RUN or DONE:** immediately returns to IDLE with all outputs at their reset values. The partial result is discarded and no `out_valid` pulse is produced.
- **Operand 0 and all-ones:** no special-casing. The recurrence handles them.

## Timing

- Accept edge E0: state becomes RUN.
- Edges E1..E(DATA_W): one bit processed per edge.
- `out_valid` is high in the cycle after edge E(DATA_W). Latency from accept to `out_valid` is DATA_W cycles.
- With `out_ready` held at 1:
  - the handshake completes in the first `out_valid` cycle;
  - `in_ready` returns the following cycle;
  - throughput is one operand per DATA_W+2 cycles.
- Backpressure stalls indefinitely in DONE without corrupting the result.

## Structure

- **Package `div3_pkg`:**
  - state enum `div3_state_t` (IDLE, RUN, DONE);
  - `REM_W = 2`;
  - a reference function `div3_model(value)` that returns quotient and remainder, for use by the bench.
- **Sub-module `div3_step`:** combinational. Inputs are `r[1:0]` and `b`; outputs are `r_next[1:0]` and `q_bit`. It is instantiated once in the RUN datapath.
- **Top level:** the FSM, shift register, quotient register, counter and handshake logic all live in `div3_serial`.

## Test plan

- **Known operands, DATA_W=8, `out_ready=1`:**
  - 0 gives `quotient=0`, `remainder=0`, `divisible=1`;
  - 255 gives 85, 0, 1;
  - 200 gives 66, 2, 0;
  - 7 gives 2, 1, 0.
  - In every case `out_valid` rises exactly 8 cycles after accept.
- **Backpressure:** operand 100, `out_ready=0` for 5 cycles after `out_valid`.
  - Required: 33/1/0 stays stable throughout, `in_ready` stays 0, and `in_valid` pulses are ignored.
  - Then `out_ready=1`: handshake completes, and `in_ready=1` the next cycle.
- **Back-to-back operands:** 9 then 10 with `in_valid` held high.
  - Required results are 3/0/1 then 3/1/0, in order.
  - The second accept happens exactly 1 cycle after the first output handshake.
- **Reset mid-run:** assert `rst_n=0` 4 cycles after accepting 150.
  - Required: `out_valid` never asserts, all outputs are 0, and `in_ready=1` after release.
  - A fresh 150 then yields 50/0/1.
- **Parameter sweep, DATA_W=5:**
  - Exhaustive check of 0..31 against `div3_model` (for example, 31 gives 10/1/0).
  - Latency is 5 cycles.
  - `divisible` matches the combinational checker for every operand.
